display_scan_controller: RTL and testbench

- Parametrised multiplexed 7-segment scan controller: the next generation of the stopwatch refresh counter.
- Detects rising edges of the slow refresh tick in the system clock domain and steps through NUM_DIGITS digit positions.
- Skips masked digits, e.g. for leading-zero blanking, and inserts a ghosting-guard blank interval between digits.
- Drives one-hot anodes plus the digit index consumed by the segment mux/decoder.

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_scan_controller_tick_edge_detect.sv | 32 +++
 rtl/display_scan_controller.sv | 98 +++++++++
 tb/tb_display_scan_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared scan states, anode polarity levels and next-digit search for the display scan controller
package display_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

    localparam logic ANODE_ON_LOW  = 1'b0;
    localparam logic ANODE_ON_HIGH = 1'b1;

    // First set mask bit at (start+k) mod n for k=0..n-1, or -1 when the mask is empty.
    // start may equal n (current index + 1 at the top digit), so one subtraction wraps it.
    function automatic int next_digit(input logic [15:0] mask, input int start, input int n);
        int idx;
        next_digit = -1;
        for (int k = 15; k >= 0; k--) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (k < n && mask[idx[3:0]]) next_digit = idx;
        end
    endfunction

endpackage

// File: rtl/display_scan_controller_tick_edge_detect.sv
// tick_edge_detect: optional 2-flop synchroniser plus rising-edge pulse (DISPLAY_SCAN_SYNC_EN enables the synchroniser)
module tick_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic tick_rise
);

    logic tick_s;
    logic tick_prev;

`ifdef DISPLAY_SCAN_SYNC_EN
    logic [1:0] sync;

    // Resynchronise the asynchronous tick; reset high so a tick high at release is no edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], tick_in};

    assign tick_s = sync[1];
`else
    assign tick_s = tick_in;
`endif

    // Previous tick level; reset high so a level already high is not an edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tick_prev <= 1'b1;
        else        tick_prev <= tick_s;

    assign tick_rise = tick_s & ~tick_prev;

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexed 7-segment scan with digit masking and ghosting blank (DISPLAY_SCAN_SYNC_EN adds tick synchroniser)
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int SEL_W            = $clog2(NUM_DIGITS),
    parameter int BLANK_CYCLES     = 8,
    parameter bit ANODE_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  refresh_tick,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      digit_sel,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  blank,
    output logic                  scan_wrap,
    output logic                  overrun
);

    localparam int               CNT_W    = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam scan_state_t      ENTRY    = BLANK_CYCLES == 0 ? DRIVE : BLANK;
    localparam logic             ON_LVL   = ANODE_ACTIVE_LOW ? ANODE_ON_LOW : ANODE_ON_HIGH;

    scan_state_t           state, state_n;
    logic [SEL_W-1:0]      sel_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  wrap_n, ovr_n;
    logic                  tick_rise;
    int                    nd;
    logic [NUM_DIGITS-1:0] on_vec;

    tick_edge_detect u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (refresh_tick),
        .tick_rise (tick_rise)
    );

    // Candidate digit: search from 0 on entry, from the next position while driving
    always_comb nd = next_digit(16'(digit_mask), state == DRIVE ? int'(digit_sel) + 1 : 0, NUM_DIGITS);

    // Next-state, next-digit, blank counter and pulse/sticky flag logic
    always_comb begin
        state_n = state;
        sel_n   = digit_sel;
        cnt_n   = cnt;
        wrap_n  = 1'b0;
        ovr_n   = overrun | (state == BLANK && tick_rise);
        if (!enable) begin
            state_n = IDLE;
            sel_n   = '0;
            cnt_n   = '0;
        end else if (state == IDLE) begin
            if (nd >= 0) begin
                state_n = ENTRY;
                sel_n   = nd[SEL_W-1:0];
                cnt_n   = '0;
            end
        end else if (~|digit_mask) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (state == BLANK) begin
            state_n = cnt == CNT_LAST ? DRIVE : BLANK;
            cnt_n   = cnt == CNT_LAST ? '0 : cnt + CNT_W'(1);
        end else if (tick_rise) begin
            state_n = ENTRY;
            sel_n   = nd[SEL_W-1:0];
            cnt_n   = '0;
            wrap_n  = nd[SEL_W-1:0] <= digit_sel;
        end
    end

    // Scan state registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            digit_sel <= '0;
            cnt       <= '0;
            scan_wrap <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            digit_sel <= sel_n;
            cnt       <= cnt_n;
            scan_wrap <= wrap_n;
            overrun   <= ovr_n;
        end

    // Anode drive gated by the live mask so a dropped digit goes dark immediately
    always_comb on_vec = state == DRIVE ? (NUM_DIGITS'(1) << digit_sel) & digit_mask : '0;

    assign anode = ON_LVL ? on_vec : ~on_vec;
    assign blank = ~|on_vec;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed checks of the 4-digit scan controller with hand-computed expectations
module tb_display_scan_controller;

`ifdef DISPLAY_SCAN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int BLK = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       refresh_tick;
    logic       enable;
    logic [3:0] digit_mask;
    logic [1:0] digit_sel;
    logic [3:0] anode;
    logic       blank;
    logic       scan_wrap;
    logic       overrun;

    int n_asserts = 0;
    int n_fail    = 0;

    display_scan_controller #(.NUM_DIGITS(4), .BLANK_CYCLES(BLK), .ANODE_ACTIVE_LOW(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .refresh_tick (refresh_tick),
        .enable       (enable),
        .digit_mask   (digit_mask),
        .digit_sel    (digit_sel),
        .anode        (anode),
        .blank        (blank),
        .scan_wrap    (scan_wrap),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raise the tick after a short dwell and return at the negedge following the advance edge
    task automatic do_tick();
        repeat (5) @(negedge clk);
        refresh_tick = 1'b1;
        repeat (LAT) @(negedge clk);
        refresh_tick = 1'b0;
    endtask

    // Called at the negedge right after a digit change: blank window, then the driven anode
    task automatic expect_step(input string tag, input int sel, input logic [3:0] an, input logic wrap);
        check({tag, " sel"}, 32'(digit_sel), sel);
        check({tag, " wrap"}, 32'(scan_wrap), 32'(wrap));
        check({tag, " blank0"}, 32'(blank), 1);
        check({tag, " anode_off"}, 32'(anode), 4'hF);
        repeat (BLK - 1) @(negedge clk);
        check({tag, " blank_last"}, 32'(blank), 1);
        @(negedge clk);
        check({tag, " anode"}, 32'(anode), 32'(an));
        check({tag, " blank_drv"}, 32'(blank), 0);
        check({tag, " wrap_end"}, 32'(scan_wrap), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        refresh_tick = 1'b0;
        enable       = 1'b0;
        digit_mask   = 4'hF;
        repeat (3) @(negedge clk);
        check("rst sel", 32'(digit_sel), 0);
        check("rst anode", 32'(anode), 4'hF);
        check("rst blank", 32'(blank), 1);
        check("rst wrap", 32'(scan_wrap), 0);
        check("rst overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle blank", 32'(blank), 1);
        check("idle anode", 32'(anode), 4'hF);

        enable = 1'b1;
        @(negedge clk);
        expect_step("m1111 entry", 0, 4'hE, 1'b0);
        do_tick(); expect_step("m1111 t1", 1, 4'hD, 1'b0);
        do_tick(); expect_step("m1111 t2", 2, 4'hB, 1'b0);
        do_tick(); expect_step("m1111 t3", 3, 4'h7, 1'b0);
        do_tick(); expect_step("m1111 t4", 0, 4'hE, 1'b1);

        digit_mask = 4'b0101;
        do_tick(); expect_step("m0101 t1", 2, 4'hB, 1'b0);
        do_tick(); expect_step("m0101 t2", 0, 4'hE, 1'b1);
        do_tick(); expect_step("m0101 t3", 2, 4'hB, 1'b0);
        do_tick(); expect_step("m0101 t4", 0, 4'hE, 1'b1);

        digit_mask = 4'b1000;
        #1;
        check("mask drop anode", 32'(anode), 4'hF);
        check("mask drop blank", 32'(blank), 1);
        do_tick(); expect_step("m1000 t1", 3, 4'h7, 1'b0);
        do_tick(); expect_step("m1000 t2", 3, 4'h7, 1'b1);
        do_tick(); expect_step("m1000 t3", 3, 4'h7, 1'b1);

        digit_mask = 4'hF;
        do_tick();
        check("ovr entry sel", 32'(digit_sel), 0);
        check("ovr entry wrap", 32'(scan_wrap), 1);
        check("ovr before", 32'(overrun), 0);
        repeat (2) @(negedge clk);
        refresh_tick = 1'b1;
        repeat (LAT) @(negedge clk);
        refresh_tick = 1'b0;
        check("ovr set", 32'(overrun), 1);
        check("ovr no advance", 32'(digit_sel), 0);
        check("ovr still blank", 32'(blank), 1);
        repeat (6 - LAT) @(negedge clk);
        check("ovr drive anode", 32'(anode), 4'hE);
        check("ovr drive sel", 32'(digit_sel), 0);

        do_tick(); expect_step("pre clear", 1, 4'hD, 1'b0);
        digit_mask = 4'b0000;
        #1;
        check("clear anode", 32'(anode), 4'hF);
        check("clear blank", 32'(blank), 1);
        @(negedge clk);
        check("clear idle blank", 32'(blank), 1);
        check("clear sel hold", 32'(digit_sel), 1);
        repeat (3) @(negedge clk);
        digit_mask = 4'b0010;
        @(negedge clk);
        expect_step("restore", 1, 4'hD, 1'b0);
        check("ovr sticky", 32'(overrun), 1);

        digit_mask = 4'hF;
        enable     = 1'b0;
        @(negedge clk);
        check("disable sel", 32'(digit_sel), 0);
        check("disable blank", 32'(blank), 1);
        enable       = 1'b1;
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        expect_step("enable+tick", 0, 4'hE, 1'b0);

        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst anode", 32'(anode), 4'hF);
        check("midrst blank", 32'(blank), 1);
        check("midrst sel", 32'(digit_sel), 0);
        check("midrst overrun", 32'(overrun), 0);
        refresh_tick = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_step("high at release", 0, 4'hE, 1'b0);
        repeat (5) @(negedge clk);
        check("held high no advance", 32'(digit_sel), 0);
        refresh_tick = 1'b0;
        repeat (3) @(negedge clk);
        refresh_tick = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        #1;
        check("rise latency early", 32'(digit_sel), 0);
        @(negedge clk);
        check("rise latency sel", 32'(digit_sel), 1);
        check("rise latency blank", 32'(blank), 1);
        refresh_tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
